// File: rtl/sw_debounce_mode.sv
// rtl/sw_debounce_mode.sv - push-switch synchroniser, debouncer and blink-rate selector
module sw_debounce_mode #(
    parameter logic [31:0] DEBOUNCE_CNT   = 32'd1000000,
    parameter logic [31:0] LONG_PRESS_CNT = 32'd100000000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sw_raw,
    output logic       sw_level,
    output logic       sw_press,
    output logic       sw_release,
    output logic       long_press,
    output logic [1:0] rate_sel,
    output logic       rate_upd
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        q1_q, q1_d;
    logic        sync_q, sync_d;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic [31:0] hold_cnt_q, hold_cnt_d;
    logic        long_fired_q, long_fired_d;
    logic        level_q, level_d;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
    logic [1:0]  rate_q, rate_d;
    logic        upd_q, upd_d;

    logic        long_hit;
    logic        db_done;
    logic [31:0] hold_inc;
    logic [1:0]  rate_next;

    // Next-state, counters and registered-output decode
    always_comb begin
        q1_d         = sw_raw;
        sync_d       = q1_q;
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_fired_d = long_fired_q;
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        rate_d       = rate_q;

        long_hit  = (hold_cnt_q == (LONG_PRESS_CNT - 32'd1)) && !long_fired_q;
        db_done   = (db_cnt_q == (DEBOUNCE_CNT - 32'd1));
        hold_inc  = (hold_cnt_q < LONG_PRESS_CNT) ? (hold_cnt_q + 32'd1) : hold_cnt_q;
        rate_next = (rate_q == 2'd2) ? 2'd0 : (rate_q + 2'd1);

        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = 32'd1;
                end
            end
            PRESS_DB: begin
                if (!sync_q) begin
                    state_d  = IDLE;
                    db_cnt_d = 32'd0;
                end else if (db_done) begin
                    state_d      = PRESSED;
                    db_cnt_d     = 32'd0;
                    press_d      = 1'b1;
                    level_d      = 1'b1;
                    hold_cnt_d   = 32'd0;
                    long_fired_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 32'd1;
                end
            end
            PRESSED: begin
                hold_cnt_d = hold_inc;
                if (long_hit) begin
                    long_d       = 1'b1;
                    long_fired_d = 1'b1;
                    rate_d       = 2'd0;
                end
                if (!sync_q) begin
                    state_d  = RELEASE_DB;
                    db_cnt_d = 32'd1;
                end
            end
            RELEASE_DB: begin
                if (!sync_q && db_done) begin
                    // Release completes: it owns this edge, so a long press
                    // landing on the same edge is dropped and the press counts
                    // as short, keeping the three pulses mutually exclusive.
                    state_d   = IDLE;
                    db_cnt_d  = 32'd0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    if (!long_fired_q) begin
                        rate_d = rate_next;
                    end
                end else begin
                    hold_cnt_d = hold_inc;
                    if (long_hit) begin
                        long_d       = 1'b1;
                        long_fired_d = 1'b1;
                        rate_d       = 2'd0;
                    end
                    if (sync_q) begin
                        state_d  = PRESSED;
                        db_cnt_d = 32'd0;
                    end else begin
                        db_cnt_d = db_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        upd_d = (rate_d != rate_q);
    end

    // State, synchroniser, counters and output registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            q1_q         <= 1'b0;
            sync_q       <= 1'b0;
            db_cnt_q     <= 32'd0;
            hold_cnt_q   <= 32'd0;
            long_fired_q <= 1'b0;
            level_q      <= 1'b0;
            press_q      <= 1'b0;
            release_q    <= 1'b0;
            long_q       <= 1'b0;
            rate_q       <= 2'd0;
            upd_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            q1_q         <= q1_d;
            sync_q       <= sync_d;
            db_cnt_q     <= db_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            long_fired_q <= long_fired_d;
            level_q      <= level_d;
            press_q      <= press_d;
            release_q    <= release_d;
            long_q       <= long_d;
            rate_q       <= rate_d;
            upd_q        <= upd_d;
        end
    end

    assign sw_level   = level_q;
    assign sw_press   = press_q;
    assign sw_release = release_q;
    assign long_press = long_q;
    assign rate_sel   = rate_q;
    assign rate_upd   = upd_q;

endmodule

// File: tb/tb_sw_debounce_mode.sv
// tb/tb_sw_debounce_mode.sv - self-checking bench for sw_debounce_mode
module tb_sw_debounce_mode;

    localparam int D  = 4;
    localparam int LP = 20;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       sw_raw;
    logic       sw_level;
    logic       sw_press;
    logic       sw_release;
    logic       long_press;
    logic [1:0] rate_sel;
    logic       rate_upd;

    sw_debounce_mode #(
        .DEBOUNCE_CNT   (32'(D)),
        .LONG_PRESS_CNT (32'(LP))
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sw_raw     (sw_raw),
        .sw_level   (sw_level),
        .sw_press   (sw_press),
        .sw_release (sw_release),
        .long_press (long_press),
        .rate_sel   (rate_sel),
        .rate_upd   (rate_upd)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: synchroniser delay line, run length of samples that
    // disagree with the accepted level, and age of the current press.
    bit         m_q1, m_sync, m_level, m_press, m_rel, m_long, m_upd, m_fired;
    int         m_run, m_age;
    logic [1:0] m_rate;

    // Scenario tallies taken from DUT outputs
    int         cyc, c_press, c_rel, c_long, c_upd, c_lvl;
    int         press_cyc, long_cyc, rel_cyc;
    logic [1:0] upd_vals[$];

    typedef struct {
        bit         raw;
        bit         lvl;
        bit         prs;
        bit         rel;
        bit         lng;
        logic [1:0] rate;
        bit         upd;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_q1 = 0; m_sync = 0; m_level = 0; m_press = 0; m_rel = 0;
        m_long = 0; m_upd = 0; m_fired = 0; m_run = 0; m_age = 0; m_rate = 2'd0;
    endtask

    task automatic model_step(input bit raw);
        bit         s;
        bit         rel_now;
        logic [1:0] old;
        s      = m_sync;
        m_sync = m_q1;
        m_q1   = raw;
        m_press = 0; m_rel = 0; m_long = 0;
        old = m_rate;
        if (s != m_level) m_run++;
        else              m_run = 0;
        rel_now = m_level && (m_run == D);
        if (m_level) begin
            if (m_age < LP) m_age++;
            if (m_age == LP && !m_fired && !rel_now) begin
                m_long  = 1;
                m_fired = 1;
                m_rate  = 2'd0;
            end
        end
        if (m_run == D) begin
            m_run = 0;
            if (m_level) begin
                m_level = 0;
                m_rel   = 1;
                if (!m_fired) m_rate = (m_rate == 2'd2) ? 2'd0 : m_rate + 2'd1;
            end else begin
                m_level = 1;
                m_press = 1;
                m_age   = 0;
                m_fired = 0;
            end
        end
        m_upd = (m_rate != old);
    endtask

    task automatic clear_tally();
        cyc = 0; c_press = 0; c_rel = 0; c_long = 0; c_upd = 0; c_lvl = 0;
        press_cyc = -1; long_cyc = -1; rel_cyc = -1;
        upd_vals.delete();
    endtask

    task automatic cycle(input bit raw);
        sw_raw = raw;
        @(posedge sys_clk);
        model_step(raw);
        #1;
        cyc++;
        chk("sw_level",   32'(sw_level),   32'(m_level));
        chk("sw_press",   32'(sw_press),   32'(m_press));
        chk("sw_release", 32'(sw_release), 32'(m_rel));
        chk("long_press", 32'(long_press), 32'(m_long));
        chk("rate_sel",   32'(rate_sel),   32'(m_rate));
        chk("rate_upd",   32'(rate_upd),   32'(m_upd));
        if (sw_level)   c_lvl++;
        if (sw_press)   begin c_press++; press_cyc = cyc; end
        if (sw_release) begin c_rel++;   rel_cyc   = cyc; end
        if (long_press) begin c_long++;  long_cyc  = cyc; end
        if (rate_upd)   begin c_upd++;   upd_vals.push_back(rate_sel); end
    endtask

    task automatic run(input bit raw, input int n);
        repeat (n) cycle(raw);
    endtask

    task automatic do_reset();
        sw_raw  = 1'b0;
        sys_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
    endtask

    // Stimulus and checking sequence
    initial begin
        int exp_w[3];
        exp_w = '{1, 2, 0};
        for (int i = 0; i < 20; i++) begin
            int e;
            e = i + 1;
            tbl[i] = '{raw: (e <= 10), lvl: (e >= 6 && e <= 15), prs: (e == 6),
                       rel: (e == 16), lng: 1'b0, rate: ((e >= 16) ? 2'd1 : 2'd0),
                       upd: (e == 16)};
        end
        clear_tally();

        sys_rst = 1'b1;
        sw_raw  = 1'b0;
        model_reset();
        #12;
        chk("reset_level",   32'(sw_level),   0);
        chk("reset_press",   32'(sw_press),   0);
        chk("reset_release", 32'(sw_release), 0);
        chk("reset_long",    32'(long_press), 0);
        chk("reset_rate",    32'(rate_sel),   0);
        chk("reset_upd",     32'(rate_upd),   0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Short press from reset, vector table
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].raw);
            chk("tbl_level",   32'(sw_level),   32'(tbl[i].lvl));
            chk("tbl_press",   32'(sw_press),   32'(tbl[i].prs));
            chk("tbl_release", 32'(sw_release), 32'(tbl[i].rel));
            chk("tbl_long",    32'(long_press), 32'(tbl[i].lng));
            chk("tbl_rate",    32'(rate_sel),   32'(tbl[i].rate));
            chk("tbl_upd",     32'(rate_upd),   32'(tbl[i].upd));
        end

        // Rate wrap: three short presses from reset
        do_reset();
        clear_tally();
        repeat (3) begin run(1, 10); run(0, 10); end
        chk("wrap_upd_count", c_upd, 3);
        for (int i = 0; i < 3; i++)
            chk("wrap_rate_seq", (i < upd_vals.size()) ? 32'(upd_vals[i]) : 32'd3, exp_w[i]);

        // Glitch rejection
        clear_tally();
        repeat (5) begin run(1, 3); run(0, 3); end
        run(0, 6);
        chk("glitch_press", c_press, 0);
        chk("glitch_level", c_lvl, 0);
        chk("glitch_rate",  32'(rate_sel), 0);
        chk("glitch_upd",   c_upd, 0);

        // Release bounce
        clear_tally();
        run(1, 10);
        repeat (3) begin run(0, 2); run(1, 1); end
        run(0, 12);
        chk("bounce_press",     c_press, 1);
        chk("bounce_release",   c_rel, 1);
        chk("bounce_press_cyc", press_cyc, 6);
        chk("bounce_rel_cyc",   rel_cyc, 25);
        chk("bounce_rate",      32'(rate_sel), 1);

        // Long press at rate 2
        run(1, 10); run(0, 10);
        chk("long_pre_rate", 32'(rate_sel), 2);
        clear_tally();
        run(1, 40);
        chk("long_count",   c_long, 1);
        chk("long_latency", long_cyc - press_cyc, LP);
        chk("long_rate",    32'(rate_sel), 0);
        chk("long_upd",     c_upd, 1);
        run(0, 10);
        chk("long_release",   c_rel, 1);
        chk("long_rel_rate",  32'(rate_sel), 0);
        chk("long_rel_upd",   c_upd, 1);

        // Long press at rate 0: no rate update
        clear_tally();
        run(1, 40); run(0, 10);
        chk("long0_count",   c_long, 1);
        chk("long0_upd",     c_upd, 0);
        chk("long0_release", c_rel, 1);
        chk("long0_rate",    32'(rate_sel), 0);

        // Asynchronous reset while pressed, then fresh debounce
        clear_tally();
        run(1, 10);
        chk("rstp_level_before", 32'(sw_level), 1);
        #2 sys_rst = 1'b1;
        model_reset();
        #1;
        chk("rstp_level", 32'(sw_level), 0);
        chk("rstp_rate",  32'(rate_sel), 0);
        chk("rstp_press", 32'(sw_press), 0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        clear_tally();
        run(1, 10);
        chk("rstp_press_cyc", press_cyc, 6);
        chk("rstp_press_cnt", c_press, 1);
        run(0, 10);

        // Random run lengths against the model
        clear_tally();
        for (int k = 0; k < 150; k++)
            run(1'($urandom_range(0, 1)), $urandom_range(1, 30));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce_mode.md
# sw_debounce_mode

Front-end conditioning stage for the board push-switch that selects the LED blink rate. It synchronises the raw switch pin into `sys_clk`, debounces it and produces clean press/release/long-press pulses. It also maintains the 2-bit blink-rate selection consumed directly by the downstream LED blink controller. A short press advances the rate; a long press forces it back to the default rate.

## Interface
- `DEBOUNCE_CNT`, default 32'd1000000, consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz); legal range ≥ 2.
- `LONG_PRESS_CNT`, default 32'd100000000, cycles the debounced level must stay pressed to declare a long press (2 s at 50 MHz); legal range ≥ 2.
- `sys_clk` input 1, single clock; all logic is on its rising edge.
- `sys_rst` input 1, asynchronous, active-high reset.
- `sw_raw` input 1, raw switch pin: asynchronous, bouncy, 1 = pressed.
- `sw_level` output 1, debounced switch level.
- `sw_press` output 1, one-cycle pulse on an accepted press.
- `sw_release` output 1, one-cycle pulse on an accepted release.
- `long_press` output 1, one-cycle pulse, at most once per press.
- `rate_sel` output 2, blink rate: 0 = 1 Hz, 1 = 0.5 Hz, 2 = 0.25 Hz; 3 is never driven.
- `rate_upd` output 1, one-cycle pulse in the cycle `rate_sel` first shows a new value.

## Operation
- **Synchroniser:** two flops, `sw_raw` → `q1` → `sync`. Only `sync` is used downstream of the synchroniser.
- **Counters:** 32-bit debounce counter `db_cnt`; 32-bit hold counter `hold_cnt`, saturating at `LONG_PRESS_CNT`; flag `long_fired`.
- **FSM states:** IDLE, PRESS_DB, PRESSED, RELEASE_DB. Reset state is IDLE.
- **IDLE:**
  - `sync`=1 → PRESS_DB, with `db_cnt`←1.
- **PRESS_DB:**
  - `sync`=0 → IDLE, with `db_cnt`←0. No output.
  - `sync`=1 and `db_cnt`==`DEBOUNCE_CNT`-1 → PRESSED. Same edge: `sw_press`←1, `sw_level`←1, `hold_cnt`←0, `long_fired`←0.
  - Otherwise `db_cnt`←`db_cnt`+1.
- **PRESSED:**
  - `hold_cnt` increments every cycle.
  - When `hold_cnt`==`LONG_PRESS_CNT`-1 and `long_fired`=0: `long_press`←1, `long_fired`←1, `rate_sel`←0.
  - `sync`=0 → RELEASE_DB, with `db_cnt`←1.
- **RELEASE_DB:**
  - `hold_cnt` keeps counting; the long-press rule above still applies.
  - `sync`=1 (bounce) → PRESSED, with `db_cnt`←0. `hold_cnt` and `long_fired` are kept.
  - `sync`=0 and `db_cnt`==`DEBOUNCE_CNT`-1 → IDLE. Same edge: `sw_release`←1, `sw_level`←0. If `long_fired`=0, `rate_sel` advances 0→1→2→0.
  - Otherwise `db_cnt`←`db_cnt`+1.
- **rate_upd:** asserted for the one cycle following any edge at which `rate_sel` changes value. No pulse if the value is unchanged (long press while already 0).
- **Pulse exclusivity:**
  - `sw_press`, `sw_release` and `long_press` are never high in the same cycle.
  - `long_press` and the release-time advance are exclusive per press.
- **Reset while pressed:** all state is cleared. If `sw_raw` stays high after reset deassertion, the block treats it as a fresh press and runs full debounce before `sw_press`.

## Timing
- **Reset values:** `sw_level`, `sw_press`, `sw_release`, `long_press`, `rate_upd` = 0; `rate_sel` = 2'd0; `q1`/`sync` = 0; state IDLE; all counters 0.
- **Press latency:** edge 1 is the first edge sampling `sw_raw`=1, with `sw_raw` steady thereafter. `sw_press` and `sw_level` go high after edge 2+`DEBOUNCE_CNT`. `sw_press` lasts exactly one cycle.
- **Release latency:** `sw_release` goes high after edge 2+`DEBOUNCE_CNT`, counted from the first edge sampling `sw_raw`=0. A short press also updates `rate_sel` at that same edge.
- **Long press:** `long_press` goes high `LONG_PRESS_CNT` cycles after `sw_press`, counting bounce cycles spent in RELEASE_DB.
- **rate_upd:** goes high in the same cycle the new `rate_sel` value is visible.
- **Glitch rejection:** any `sync` pulse shorter than `DEBOUNCE_CNT` cycles produces no output change.
- All outputs are registered.

## Test plan
All scenarios use `DEBOUNCE_CNT`=4 and `LONG_PRESS_CNT`=20.
- **Reset:** assert `sys_rst` mid-cycle with `sw_raw`=1 → all outputs 0 immediately (asynchronous). Release reset, hold `sw_raw`=1 → `sw_press` pulses after edge 6.
- **Short press:** raise `sw_raw` at edge 1 and hold 10 cycles, then drop → `sw_press` after edge 6. `sw_release` occurs 6 edges after the drop, with `rate_sel` 0→1 and a one-cycle `rate_upd`.
- **Rate wrap:** three short presses → `rate_sel` sequence 1, 2, 0, with three `rate_upd` pulses.
- **Glitch rejection:** 3-cycle `sw_raw` high pulses repeated 5 times → no `sw_press`, `sw_level` stays 0, `rate_sel` unchanged.
- **Release bounce:** during release, toggle `sw_raw` low 2 cycles / high 1 cycle → no `sw_release` until 4 stable low `sync` samples. Exactly one `sw_press` and one `sw_release` occur.
- **Long press:** with `rate_sel`=2, hold for 40 cycles → `long_press` pulses once, 20 cycles after `sw_press`, with `rate_sel`→0 and `rate_upd`. On release, `sw_release` pulses and `rate_sel` stays 0. Repeat at `rate_sel`=0 → `long_press` pulses, no `rate_upd`.
